// File: rtl/pid_csr_if.sv
// pid_csr_if: Avalon-MM word-access bus between the master and the PID CSR block
interface pid_csr_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic [31:0]           writedata;
    logic                  read;
    logic [31:0]           readdata;
    logic                  waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pid_csr.sv
// pid_csr: Avalon-MM register file with shadowed PID coefficients, sticky saturation status and wait states
module pid_csr #(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5049_4401
) (
    input  logic               clk,
    input  logic               reset,
    pid_csr_if.slave           amm,
    input  logic               pid_sample,
    input  logic               pid_sat_hi,
    input  logic               pid_sat_lo,
    output logic signed [31:0] kp,
    output logic signed [31:0] ki,
    output logic signed [31:0] kd,
    output logic signed [31:0] setpoint,
    output logic signed [31:0] out_min,
    output logic signed [31:0] out_max,
    output logic               pid_enable,
    output logic               integ_clr
);
    localparam logic [31:0] MIN_RST = 32'h8000_0000;
    localparam logic [31:0] MAX_RST = 32'h7FFF_FFFF;

    logic [3:0]  cnt;
    logic        req, accept, wr, rd, valid;
    logic [3:0]  idx;
    logic [31:0] wd, rd_mux;
    logic [31:0] kp_s, ki_s, kd_s, sp_s, min_s, max_s;
    logic        pending, sat_hi, sat_lo, addr_err;
    logic [31:0] sat_count;
    logic        w_ctrl, w_st, commit_now;

    assign req      = amm.read | amm.write;
    assign accept   = req && (cnt == 4'(WAIT_STATES));
    assign amm.waitrequest = !accept;
    assign wr       = accept && amm.write;
    assign rd       = accept && amm.read && !amm.write;
    assign valid    = amm.address < ADDR_WIDTH'(10);
    assign idx      = amm.address[3:0];
    assign wd       = amm.writedata;
    assign w_ctrl   = wr && valid && idx == 4'd0;
    assign w_st     = wr && valid && idx == 4'd7;
    assign commit_now = pending && pid_sample;

    // Wait-state counter: counts while a request is held, clears when idle or on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (!req || accept) ? 4'd0 : cnt + 4'd1;
    end

    // Shadow registers take bus writes; active outputs copy them on a committed sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kp_s <= '0; ki_s <= '0; kd_s <= '0; sp_s <= '0; min_s <= MIN_RST; max_s <= MAX_RST;
            kp <= '0; ki <= '0; kd <= '0; setpoint <= '0; out_min <= MIN_RST; out_max <= MAX_RST;
        end else begin
            if (wr && valid) begin
                case (idx)
                    4'd1: kp_s  <= wd;
                    4'd2: ki_s  <= wd;
                    4'd3: kd_s  <= wd;
                    4'd4: sp_s  <= wd;
                    4'd5: min_s <= wd;
                    4'd6: max_s <= wd;
                    default: ;
                endcase
            end
            if (commit_now) begin
                kp <= kp_s; ki <= ki_s; kd <= kd_s;
                setpoint <= sp_s; out_min <= min_s; out_max <= max_s;
            end
        end
    end

    // CTRL side effects: enable bit, commit request and one-cycle integrator clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pid_enable <= 1'b0;
            integ_clr  <= 1'b0;
            pending    <= 1'b0;
        end else begin
            pid_enable <= w_ctrl ? wd[0] : pid_enable;
            integ_clr  <= w_ctrl && wd[2];
            pending    <= (w_ctrl && wd[1]) ? 1'b1 : (commit_now ? 1'b0 : pending);
        end
    end

    // Sticky status flags: a new event beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            sat_hi   <= pid_sat_hi | (sat_hi & !(w_st && wd[0]));
            sat_lo   <= pid_sat_lo | (sat_lo & !(w_st && wd[1]));
            addr_err <= (accept && !valid) | (addr_err & !(w_st && wd[3]));
        end
    end

    // Saturation cycle counter: any write clears it (wins over increment), sticks at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_count <= '0;
        else if (wr && valid && idx == 4'd8)
            sat_count <= '0;
        else if ((pid_sat_hi || pid_sat_lo) && sat_count != 32'hFFFF_FFFF)
            sat_count <= sat_count + 32'd1;
    end

    // Read mux: shadow values for coefficients, zero for unmapped addresses
    always_comb begin
        rd_mux = '0;
        case (idx)
            4'd0: rd_mux = {31'b0, pid_enable};
            4'd1: rd_mux = kp_s;
            4'd2: rd_mux = ki_s;
            4'd3: rd_mux = kd_s;
            4'd4: rd_mux = sp_s;
            4'd5: rd_mux = min_s;
            4'd6: rd_mux = max_s;
            4'd7: rd_mux = {28'b0, addr_err, pending, sat_lo, sat_hi};
            4'd8: rd_mux = sat_count;
            4'd9: rd_mux = ID_VALUE;
            default: rd_mux = '0;
        endcase
        if (!valid)
            rd_mux = '0;
    end

    // Registered read data: loaded at the end of a read accept, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            amm.readdata <= '0;
        else if (rd)
            amm.readdata <= rd_mux;
    end
endmodule
